nfet_bank_timed: RTL and testbench
==================================

// Module: nfet_bank_timed
// PURPOSE
//  Clocked, synthesizable timing model of a bank of open-drain n-FET inverters for FPGA emulation.
//  Each channel drives drain = ~gate | source.
//  Edges are delayed by asymmetric tick counts: slow pull-up rise, fast RDS fall.
//  Pulses shorter than the delay are swallowed (inertial), reported as glitches.
//  Used wherever the gate-level netlist needs cycle-deterministic transistor delays.
// PARAMETERS
//  CHANNELS    8    number of independent FET channels
//  RISE_TICKS  4    ticks for 0->1 (pull-up charging load); legal range 1..255
//  FALL_TICKS  1    ticks for 1->0 (FET discharging load); legal range 1..255
//  RESET_VAL   1'b1 drain value of every channel during/after reset (pulled up)
//  GLITCH_W    8    width of saturating glitch counter
// PORTS
//  clk         in   1         system clock
//  rst_n       in   1         asynchronous active-low reset
//  tick_en     in   1         delay time base; counters advance only when 1
//  source      in   CHANNELS  per-channel source level (synchronous to clk)
//  gate        in   CHANNELS  per-channel gate level (synchronous to clk)
//  drain       out  CHANNELS  delayed output, registered
//  busy        out  CHANNELS  1 = channel has a pending transition
//  glitch      out  CHANNELS  1-cycle pulse: pending transition cancelled
//  settled     out  1         1 = no channel busy (NOR of busy)
//  glitch_cnt  out  GLITCH_W  total cancelled transitions, saturating
// BEHAVIOUR
//  - target[i] = ~gate[i] | source[i], combinational from inputs; never drives drain directly.
//  - Reset (rst_n=0, async):
//    - drain = {CHANNELS{RESET_VAL}}; busy = 0; glitch = 0; glitch_cnt = 0; settled = 1.
//    - Reset mid-transition discards the pending edge.
//  - Per-channel FSM, states IDLE / PEND:
//    - IDLE, target==drain: stay.
//    - IDLE, target!=drain, tick_en=1: D = RISE_TICKS if target=1, else FALL_TICKS.
//      - D==1: drain<=target this edge, stay IDLE.
//      - D>1: go PEND, cnt<=D-2, busy<=1.
//    - IDLE, target!=drain, tick_en=0: stay IDLE; the mismatch is not yet counted.
//    - PEND, target==drain (cancel): go IDLE, busy<=0, glitch<=1 for one cycle.
//      - Cancel is evaluated every clock, independent of tick_en.
//    - PEND, target!=drain, tick_en=1:
//      - cnt==0: drain<=target, go IDLE, busy<=0.
//      - cnt!=0: cnt<=cnt-1.
//    - PEND, tick_en=0, no cancel: hold cnt.
//  - Net rule: drain changes at the D-th tick_en edge over which target continuously differed from drain.
//    With tick_en tied 1, latency is D cycles.
//  - Retarget: target is binary, so in PEND it either equals the pending value or cancels; no redirect case.
//  - glitch_cnt: adds popcount(glitch) each cycle and saturates at all-ones (no wrap).
//    Simultaneous glitches on several channels all count.
//  - busy, drain, glitch, glitch_cnt are flops; settled is combinational from busy.
//  - Counter width: CW = $clog2(max(RISE_TICKS,FALL_TICKS)) (min 1). Out-of-range parameters: $error at elaboration.
// STRUCTURE
//  - Package nfet_pkg:
//    - typedef enum {ST_IDLE, ST_PEND} nfet_state_t
//    - localparam MAX_TICKS = 255
//    - function ticks_cw(int) returning CW
//  - Sub-module nfet_chan: one FSM + counter, ports clk, rst_n, tick_en, target, drain, busy, glitch.
//    Instantiated CHANNELS times by generate.
//  - Top holds target logic, glitch popcount/saturating adder and settled.
// TESTING
//  1. Reset with gate=0: drain=all-ones, busy=0, settled=1, glitch_cnt=0.
//  2. tick_en=1, ch0 gate 0->1 (source=0): drain[0] falls exactly 1 cycle later.
//     gate 1->0: drain[0] rises exactly 4 cycles later; busy[0] high for 3 cycles.
//  3. ch1 gate=0 pulse of 2 cycles (rise needs 4): drain[1] never rises; glitch[1] pulses once; glitch_cnt=1.
//  4. tick_en=1 every 3rd cycle, rise on ch2: drain[2] rises on the 4th tick_en edge after mismatch.
//     Cancel while tick_en=0 still fires glitch.
//  5. GLITCH_W=2, cancel 3 channels in one cycle, then 2 more: glitch_cnt=3 then holds 3.
//  6. rst_n pulsed low while ch3 is PEND: drain returns to RESET_VAL asynchronously; no late edge or glitch after release.

Source files
------------

// File: rtl/nfet_pkg.sv
// nfet_pkg: shared state type, tick limits and counter sizing for the n-FET bank.
package nfet_pkg;
    typedef enum logic {ST_IDLE, ST_PEND} nfet_state_t;
    localparam int MAX_TICKS = 255;
    function automatic int ticks_cw(input int max_ticks);
        return (max_ticks <= 1) ? 1 : $clog2(max_ticks);
    endfunction
endpackage

// File: rtl/nfet_chan.sv
// nfet_chan: one inertial-delay channel; drain follows target after RISE/FALL ticks,
// a pending edge is cancelled (glitch) as soon as target returns to drain.
module nfet_chan
    import nfet_pkg::*;
#(
    parameter int   RISE_TICKS = 4,
    parameter int   FALL_TICKS = 1,
    parameter logic RESET_VAL  = 1'b1,
    parameter int   CW         = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_en,
    input  logic target,
    output logic drain,
    output logic busy,
    output logic glitch
);
    localparam logic RISE_ONE = (RISE_TICKS == 1);
    localparam logic FALL_ONE = (FALL_TICKS == 1);
    localparam logic [CW-1:0] RISE_LD = CW'(RISE_TICKS > 1 ? RISE_TICKS - 2 : 0);
    localparam logic [CW-1:0] FALL_LD = CW'(FALL_TICKS > 1 ? FALL_TICKS - 2 : 0);
    nfet_state_t state;
    logic [CW-1:0] cnt;
    // The first tick is consumed on the IDLE->PEND edge, hence the D-2 load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            drain  <= RESET_VAL;
            busy   <= 1'b0;
            glitch <= 1'b0;
        end else begin
            glitch <= 1'b0;
            if (state == ST_IDLE) begin
                if (target != drain && tick_en) begin
                    if (target ? RISE_ONE : FALL_ONE) begin
                        drain <= target;
                    end else begin
                        state <= ST_PEND;
                        cnt   <= target ? RISE_LD : FALL_LD;
                        busy  <= 1'b1;
                    end
                end
            end else if (target == drain) begin
                state  <= ST_IDLE;
                busy   <= 1'b0;
                glitch <= 1'b1;
            end else if (tick_en) begin
                if (cnt == '0) begin
                    drain <= target;
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/nfet_bank_timed.sv
// nfet_bank_timed: bank of timed open-drain n-FET inverters (drain = ~gate | source)
// with per-channel inertial delays and a saturating glitch counter.
module nfet_bank_timed
    import nfet_pkg::*;
#(
    parameter int   CHANNELS   = 8,
    parameter int   RISE_TICKS = 4,
    parameter int   FALL_TICKS = 1,
    parameter logic RESET_VAL  = 1'b1,
    parameter int   GLITCH_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick_en,
    input  logic [CHANNELS-1:0] source,
    input  logic [CHANNELS-1:0] gate,
    output logic [CHANNELS-1:0] drain,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] glitch,
    output logic                settled,
    output logic [GLITCH_W-1:0] glitch_cnt
);
    localparam int CW = ticks_cw(RISE_TICKS > FALL_TICKS ? RISE_TICKS : FALL_TICKS);
    localparam int PW = $clog2(CHANNELS + 1);
    localparam int SW = GLITCH_W + PW;
    if (RISE_TICKS < 1 || RISE_TICKS > MAX_TICKS) begin : g_bad_rise
        $error("nfet_bank_timed: RISE_TICKS out of range 1..255");
    end
    if (FALL_TICKS < 1 || FALL_TICKS > MAX_TICKS) begin : g_bad_fall
        $error("nfet_bank_timed: FALL_TICKS out of range 1..255");
    end
    logic [CHANNELS-1:0] target;
    logic [PW-1:0]       pop;
    logic [SW-1:0]       sum;
    assign target  = ~gate | source;
    assign settled = ~|busy;
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        nfet_chan #(
            .RISE_TICKS(RISE_TICKS),
            .FALL_TICKS(FALL_TICKS),
            .RESET_VAL (RESET_VAL),
            .CW        (CW)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .tick_en(tick_en),
            .target (target[i]),
            .drain  (drain[i]),
            .busy   (busy[i]),
            .glitch (glitch[i])
        );
    end
    always_comb begin
        pop = '0;
        for (int i = 0; i < CHANNELS; i++) pop = pop + PW'(glitch[i]);
        sum = SW'(glitch_cnt) + SW'(pop);
    end
    // Any carry into the extension bits means the count would wrap: clamp instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) glitch_cnt <= '0;
        else        glitch_cnt <= |sum[SW-1:GLITCH_W] ? '1 : sum[GLITCH_W-1:0];
    end
endmodule

// File: tb/tb_nfet_bank_timed.sv
// tb_nfet_bank_timed: directed checks of delays, cancellation, tick gating,
// glitch saturation and async reset for nfet_bank_timed.
module tb_nfet_bank_timed;
    logic       clk = 1'b0, rst_n = 1'b0, tick_en = 1'b1;
    logic [7:0] source = '0, gate = '0, gate2 = '0;
    logic [7:0] drain, busy, glitch, glitch_cnt;
    logic [7:0] drain2, busy2, glitch2;
    logic [1:0] glitch_cnt2;
    logic       settled, settled2;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    nfet_bank_timed dut (
        .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .source(source), .gate(gate),
        .drain(drain), .busy(busy), .glitch(glitch), .settled(settled), .glitch_cnt(glitch_cnt)
    );

    nfet_bank_timed #(.GLITCH_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .source(source), .gate(gate2),
        .drain(drain2), .busy(busy2), .glitch(glitch2), .settled(settled2), .glitch_cnt(glitch_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        step(2);
        chk("rst_drain", drain, 8'hff);
        chk("rst_busy", busy, 8'h00);
        chk("rst_settled", settled, 1'b1);
        chk("rst_gcnt", glitch_cnt, 8'h00);
        chk("rst_glitch", glitch, 8'h00);
        chk("rst_drain2", drain2, 8'hff);
        #2 rst_n = 1'b1;
        step();
        // fall takes one edge, rise takes four
        gate[0] = 1'b1;
        chk("fall_pre", drain[0], 1'b1);
        step();
        chk("fall_d0", drain[0], 1'b0);
        chk("fall_busy", busy[0], 1'b0);
        gate[0] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("rise_d0_%0d", k), drain[0], k == 4);
            chk($sformatf("rise_busy_%0d", k), busy[0], k < 4);
            chk($sformatf("rise_settled_%0d", k), settled, k == 4);
        end
        // 2-cycle pulse on ch1 is swallowed
        gate[1] = 1'b1;
        step();
        chk("ch1_low", drain[1], 1'b0);
        gate[1] = 1'b0;
        step(2);
        chk("ch1_pend", busy[1], 1'b1);
        gate[1] = 1'b1;
        step();
        chk("ch1_glitch", glitch, 8'h02);
        chk("ch1_drain", drain[1], 1'b0);
        chk("ch1_gcnt_pre", glitch_cnt, 8'h00);
        step();
        chk("ch1_glitch_off", glitch, 8'h00);
        chk("ch1_gcnt", glitch_cnt, 8'h01);
        // tick_en every third cycle on ch2
        gate[2] = 1'b1;
        step();
        chk("ch2_low", drain[2], 1'b0);
        gate[2] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick_en = (k % 3 == 0);
            step();
            chk($sformatf("tick_d2_%0d", k), drain[2], k == 12);
            chk($sformatf("tick_busy_%0d", k), busy[2], k >= 3 && k < 12);
        end
        tick_en = 1'b1;
        gate[2] = 1'b1;
        step();
        chk("ch2_fall", drain[2], 1'b0);
        gate[2] = 1'b0;
        step();
        chk("ch2_pend", busy[2], 1'b1);
        tick_en = 1'b0;
        gate[2] = 1'b1;
        step();
        chk("ch2_cancel_notick", glitch, 8'h04);
        chk("ch2_cancel_busy", busy[2], 1'b0);
        step();
        chk("ch2_gcnt", glitch_cnt, 8'h02);
        tick_en = 1'b1;
        // saturation with a 2-bit counter
        gate2 = 8'h07;
        step();
        chk("sat_fall", drain2, 8'hf8);
        gate2 = 8'h00;
        step();
        chk("sat_pend3", busy2, 8'h07);
        gate2 = 8'h07;
        step();
        chk("sat_glitch3", glitch2, 8'h07);
        step();
        chk("sat_cnt3", glitch_cnt2, 2'd3);
        gate2 = 8'h04;
        step();
        chk("sat_pend2", busy2, 8'h03);
        gate2 = 8'h07;
        step();
        chk("sat_glitch2", glitch2, 8'h03);
        step();
        chk("sat_hold", glitch_cnt2, 2'd3);
        step();
        chk("sat_hold2", glitch_cnt2, 2'd3);
        // async reset while ch3 is pending
        gate[3] = 1'b1;
        step();
        chk("ch3_low", drain[3], 1'b0);
        gate[3] = 1'b0;
        step();
        chk("ch3_pend", busy[3], 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_drain", drain, 8'hff);
        chk("arst_busy", busy, 8'h00);
        chk("arst_gcnt", glitch_cnt, 8'h00);
        step();
        #2 rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("post_d3_%0d", k), drain[3], 1'b1);
            chk($sformatf("post_glitch_%0d", k), glitch, 8'h00);
            chk($sformatf("post_busy_%0d", k), busy, 8'h00);
        end
        chk("post_gcnt", glitch_cnt, 8'h00);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
